// File: rtl/truth_table_checker.sv
// -----------------------------------------------------------------------------
// truth_table_checker
//
// Self-checking monitor for a small combinational block. It accepts
// (input vector, observed output) sample pairs over a valid/ready handshake
// and compares each observed output against a truth table held in the EXPECT
// parameter. It records which rows have been seen, counts mismatching samples
// with a saturating counter, and raises done/pass once every row is covered.
//
// Parameters
//   N_IN    width of the input vector; the table has 2**N_IN rows
//   EXPECT  expected output per row; bit i is the expected y for abc == i
//   ERR_W   width of the saturating mismatch counter
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   clear          synchronous restart, same effect as reset; wins over accept
//   valid          a sample (abc, y) is present this cycle
//   abc            input vector of the sample
//   y              observed output of the sample
//   ready          checker accepts a sample this cycle (low once done)
//   mismatch       one-cycle pulse: last accepted sample disagreed with EXPECT
//   err_count      number of mismatching samples, saturates at all-ones
//   covered        bit i set once row i has been accepted at least once
//   done           all rows covered; held until reset/clear
//   pass           done with no mismatches
//   first_err_vld  first mismatch captured (optional feature)
//   first_err_row  row of the first mismatch (optional feature)
//
// Build option
//   TT_CHECK_FIRST_ERR_EN  when defined, captures the row of the first
//                          mismatching sample after reset/clear. When not
//                          defined, first_err_vld/first_err_row are tied to 0.
// -----------------------------------------------------------------------------
module truth_table_checker #(
  parameter int                 N_IN   = 3,
  parameter logic [2**N_IN-1:0] EXPECT = 8'b11101000,
  parameter int                 ERR_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 valid,
  input  logic [N_IN-1:0]      abc,
  input  logic                 y,
  output logic                 ready,
  output logic                 mismatch,
  output logic [ERR_W-1:0]     err_count,
  output logic [2**N_IN-1:0]   covered,
  output logic                 done,
  output logic                 pass,
  output logic                 first_err_vld,
  output logic [N_IN-1:0]      first_err_row
);

  localparam int ROWS = 2**N_IN;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } state_t;

  state_t              state_q,    state_d;
  logic                ready_q,    ready_d;
  logic                mismatch_q, mismatch_d;
  logic [ERR_W-1:0]    err_q,      err_d;
  logic [ROWS-1:0]     covered_q,  covered_d;
  logic                done_q,     done_d;

  logic                accept;
  logic                exp_bit;
  logic                sample_bad;
  logic [ROWS-1:0]     row_onehot;

  // Case-inequality: an X/Z on y, or an X/Z on abc (which makes exp_bit
  // unknown), is flagged as a mismatch rather than silently matching.
  always_comb begin
    accept     = valid && ready_q;
    exp_bit    = EXPECT[abc];
    sample_bad = (y !== exp_bit);
    row_onehot = '0;
    row_onehot[abc] = 1'b1;
  end

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path through the block leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    covered_d  = covered_q;
    done_d     = done_q;

    if (clear) begin
      state_d   = IDLE;
      ready_d   = 1'b1;
      err_d     = '0;
      covered_d = '0;
      done_d    = 1'b0;
    end else if (accept) begin
      covered_d  = covered_q | row_onehot;
      mismatch_d = sample_bad;
      if (sample_bad && (err_q != {ERR_W{1'b1}})) begin
        err_d = err_q + 1'b1;
      end
      // The sample that fills the last missing row ends the run; ready
      // drops on the same edge so nothing more is counted.
      if (&covered_d) begin
        state_d = DONE;
        done_d  = 1'b1;
        ready_d = 1'b0;
      end else begin
        state_d = CHECK;
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      covered_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      covered_q  <= covered_d;
      done_q     <= done_d;
    end
  end

  assign ready     = ready_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_q;
  assign covered   = covered_q;
  assign done      = done_q;
  assign pass      = done_q && (err_q == '0);

`ifdef TT_CHECK_FIRST_ERR_EN
  logic            fe_vld_q, fe_vld_d;
  logic [N_IN-1:0] fe_row_q, fe_row_d;

  always_comb begin
    fe_vld_d = fe_vld_q;
    fe_row_d = fe_row_q;
    if (clear) begin
      fe_vld_d = 1'b0;
      fe_row_d = '0;
    end else if (accept && sample_bad && !fe_vld_q) begin
      fe_vld_d = 1'b1;
      fe_row_d = abc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fe_vld_q <= 1'b0;
      fe_row_q <= '0;
    end else begin
      fe_vld_q <= fe_vld_d;
      fe_row_q <= fe_row_d;
    end
  end

  assign first_err_vld = fe_vld_q;
  assign first_err_row = fe_row_q;
`else
  assign first_err_vld = 1'b0;
  assign first_err_row = '0;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// -----------------------------------------------------------------------------
// tb_truth_table_checker
//
// Bench for truth_table_checker with its default 3-input majority table.
// Samples are driven after the falling edge, taken on the rising edge and
// outputs are compared on the following falling edge. A small reference
// model (coverage, saturating error count, done, first error) produces every
// expected value; expected mismatch pulses go through a queue.
// -----------------------------------------------------------------------------
module tb_truth_table_checker;

  localparam int N_IN  = 3;
  localparam int ROWS  = 8;
  localparam int ERR_W = 4;

  logic              clk;
  logic              reset;
  logic              clear;
  logic              valid;
  logic [N_IN-1:0]   abc;
  logic              y;
  logic              ready;
  logic              mismatch;
  logic [ERR_W-1:0]  err_count;
  logic [ROWS-1:0]   covered;
  logic              done;
  logic              pass;
  logic              first_err_vld;
  logic [N_IN-1:0]   first_err_row;

  truth_table_checker #(
    .N_IN   (N_IN),
    .EXPECT (8'b11101000),
    .ERR_W  (ERR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .valid         (valid),
    .abc           (abc),
    .y             (y),
    .ready         (ready),
    .mismatch      (mismatch),
    .err_count     (err_count),
    .covered       (covered),
    .done          (done),
    .pass          (pass),
    .first_err_vld (first_err_vld),
    .first_err_row (first_err_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] abc;
    logic       y;
    logic       mis;
  } vec_t;

  vec_t tbl [ROWS];

  int n_checks;
  int n_errors;
  bit exp_q [$];

  // Reference model state
  logic [ROWS-1:0] m_cov;
  int              m_err;
  bit              m_done;
  bit              m_fe_vld;
  logic [2:0]      m_fe_row;

  function automatic bit maj(logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cov    = '0;
    m_err    = 0;
    m_done   = 1'b0;
    m_fe_vld = 1'b0;
    m_fe_row = '0;
    exp_q.delete();
  endtask

  task automatic check_state(input string tag);
    check({tag, " ready"},     32'(ready),     32'(!m_done));
    check({tag, " err_count"}, 32'(err_count), 32'(m_err));
    check({tag, " covered"},   32'(covered),   32'(m_cov));
    check({tag, " done"},      32'(done),      32'(m_done));
    check({tag, " pass"},      32'(pass),      32'(m_done && (m_err == 0)));
`ifdef TT_CHECK_FIRST_ERR_EN
    check({tag, " first_err_vld"}, 32'(first_err_vld), 32'(m_fe_vld));
    check({tag, " first_err_row"}, 32'(first_err_row), 32'(m_fe_row));
`else
    check({tag, " first_err_vld"}, 32'(first_err_vld), 32'd0);
    check({tag, " first_err_row"}, 32'(first_err_row), 32'd0);
`endif
  endtask

  // Drive one sample for one cycle; valid stays high if the caller sends
  // again immediately, giving back-to-back samples.
  task automatic send(input string tag, input logic [2:0] a, input logic yy,
                      input bit exp_mis);
    valid = 1'b1;
    abc   = a;
    y     = yy;
    if (!m_done) begin
      exp_q.push_back(exp_mis);
      m_cov[a] = 1'b1;
      if (exp_mis && m_err < (2**ERR_W - 1)) m_err++;
      if (exp_mis && !m_fe_vld) begin
        m_fe_vld = 1'b1;
        m_fe_row = a;
      end
      if (&m_cov) m_done = 1'b1;
    end else begin
      exp_q.push_back(1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      check({tag, " mismatch"}, 32'(mismatch), 32'(exp_q.pop_front()));
    end
    check_state(tag);
  endtask

  task automatic idle(input string tag, input int n);
    valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " idle mismatch"}, 32'(mismatch), 32'd0);
    end
    check_state(tag);
  endtask

  // Clear pulse, optionally with a valid sample in the same cycle to show
  // that clear wins over the accept.
  task automatic do_clear(input string tag, input bit with_valid);
    clear = 1'b1;
    valid = with_valid;
    abc   = 3'd5;
    y     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    valid = 1'b0;
    model_reset();
    check({tag, " mismatch"}, 32'(mismatch), 32'd0);
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    // Majority of three inputs, all observed outputs correct.
    tbl[0] = '{3'd0, 1'b0, 1'b0};
    tbl[1] = '{3'd1, 1'b0, 1'b0};
    tbl[2] = '{3'd2, 1'b0, 1'b0};
    tbl[3] = '{3'd3, 1'b1, 1'b0};
    tbl[4] = '{3'd4, 1'b0, 1'b0};
    tbl[5] = '{3'd5, 1'b1, 1'b0};
    tbl[6] = '{3'd6, 1'b1, 1'b0};
    tbl[7] = '{3'd7, 1'b1, 1'b0};

    reset = 1'b1;
    clear = 1'b0;
    valid = 1'b0;
    abc   = '0;
    y     = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("reset mismatch", 32'(mismatch), 32'd0);
    check_state("reset");
    @(negedge clk);
    reset = 1'b0;

    // 1: full table in order, all correct
    for (int i = 0; i < ROWS; i++) begin
      send("t1", tbl[i].abc, tbl[i].y, tbl[i].mis);
    end
    check("t1 covered all", 32'(covered), 32'hFF);
    check("t1 pass", 32'(pass), 32'd1);

    // 5: valid with a wrong y while done is ignored, then clear
    send("t5 ignored", 3'd2, 1'b1, 1'b0);
    send("t5 ignored2", 3'd0, 1'b1, 1'b0);
    check("t5 err_count held", 32'(err_count), 32'd0);
    valid = 1'b0;
    do_clear("t5 clear", 1'b0);
    check("t5 ready after clear", 32'(ready), 32'd1);

    // 2: row 3 inverted
    for (int i = 0; i < ROWS; i++) begin
      if (i == 3) send("t2", tbl[i].abc, ~tbl[i].y, 1'b1);
      else        send("t2", tbl[i].abc, tbl[i].y, tbl[i].mis);
    end
    check("t2 err_count", 32'(err_count), 32'd1);
    check("t2 pass", 32'(pass), 32'd0);

    // 3: rows 0..6, idle gap, then row 7; clear coincides with a valid sample
    do_clear("t3 clear", 1'b1);
    for (int i = 0; i < ROWS - 1; i++) begin
      send("t3", tbl[i].abc, tbl[i].y, tbl[i].mis);
    end
    idle("t3 gap", 5);
    check("t3 covered partial", 32'(covered), 32'h7F);
    check("t3 not done", 32'(done), 32'd0);
    send("t3 last", tbl[7].abc, tbl[7].y, tbl[7].mis);
    check("t3 done", 32'(done), 32'd1);

    // 4: twenty wrong samples on a single row, counter saturates
    valid = 1'b0;
    do_clear("t4 clear", 1'b0);
    for (int i = 0; i < 20; i++) begin
      send("t4", 3'd0, ~maj(3'd0), 1'b1);
    end
    check("t4 saturated", 32'(err_count), 32'd15);
    // Repeated correct row: coverage and count unchanged
    send("t4 repeat ok", 3'd0, maj(3'd0), 1'b0);

    // 6: async reset mid-sequence, then full replay
    valid = 1'b0;
    do_clear("t6 clear", 1'b0);
    for (int i = 0; i < 4; i++) begin
      send("t6 pre", 3'(i), (i == 1) ? ~maj(3'(i)) : maj(3'(i)),
           (i == 1) ? 1'b1 : 1'b0);
    end
    valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("t6 async covered", 32'(covered), 32'd0);
    check("t6 async err_count", 32'(err_count), 32'd0);
    check_state("t6 async");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      send("t6 replay", tbl[i].abc, tbl[i].y, tbl[i].mis);
    end
    check("t6 pass", 32'(pass), 32'd1);
    valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
